// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus between the pipeline and the branch predictor.
// master: pipeline side (drives fetch PC and resolution info).
// slave : predictor side (drives prediction, miss flags and redirect PC).
interface branch_predictor_if #(
  parameter int WORD_SIZE = 16
);
  // IF-stage lookup
  logic                 pc_IF;
  logic [WORD_SIZE-1:0] pc_IF_w;
  logic                 pred_taken_IF;
  logic [WORD_SIZE-1:0] pred_next_pc;
  // ID-stage unconditional jump resolution
  logic                 j_valid_ID;
  logic [WORD_SIZE-1:0] j_pc_ID;
  logic                 j_pred_taken_ID;
  logic [WORD_SIZE-1:0] j_pred_target_ID;
  logic [WORD_SIZE-1:0] j_target_ID;
  // EX-stage conditional branch resolution
  logic                 b_valid_EX;
  logic [WORD_SIZE-1:0] b_pc_EX;
  logic                 b_pred_taken_EX;
  logic [WORD_SIZE-1:0] b_pred_target_EX;
  logic                 b_taken_EX;
  logic [WORD_SIZE-1:0] b_target_EX;
  // Redirect to hazard unit / PC mux
  logic                 jump_miss;
  logic                 i_branch_miss;
  logic [WORD_SIZE-1:0] correct_pc;

  modport master (
    output pc_IF_w,
    input  pred_taken_IF, pred_next_pc,
    output j_valid_ID, j_pc_ID, j_pred_taken_ID, j_pred_target_ID, j_target_ID,
    output b_valid_EX, b_pc_EX, b_pred_taken_EX, b_pred_target_EX, b_taken_EX, b_target_EX,
    input  jump_miss, i_branch_miss, correct_pc
  );

  modport slave (
    input  pc_IF_w,
    output pred_taken_IF, pred_next_pc,
    input  j_valid_ID, j_pc_ID, j_pred_taken_ID, j_pred_target_ID, j_target_ID,
    input  b_valid_EX, b_pc_EX, b_pred_taken_EX, b_pred_target_EX, b_taken_EX, b_target_EX,
    output jump_miss, i_branch_miss, correct_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Next-PC predictor (direct-mapped BTB, 2-bit saturating counters) with
// ID-stage jump and EX-stage branch misprediction checking.
// Optional feature macro: BP_STATS_EN adds saturating resolve/miss counters
// (stat_resolved, stat_miss). Default build omits them.
module branch_predictor #(
  parameter int WORD_SIZE    = 16,
  parameter int BTB_IDX_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_predictor_if.slave      bus
`ifdef BP_STATS_EN
  ,
  output logic [15:0]            stat_resolved,
  output logic [15:0]            stat_miss
`endif
);
  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - BTB_IDX_BITS;
  localparam logic [WORD_SIZE-1:0] PC_ONE = WORD_SIZE'(1);

  // BTB storage
  logic                 valid  [ENTRIES];
  logic [TAG_W-1:0]     tag    [ENTRIES];
  logic [WORD_SIZE-1:0] target [ENTRIES];
  logic [1:0]           ctr    [ENTRIES];

  logic [BTB_IDX_BITS-1:0] lk_idx, j_idx, b_idx;
  logic [TAG_W-1:0]        lk_tag, j_tag, b_tag;
  logic                    lk_hit, b_tag_hit, jump_we;
  logic [WORD_SIZE-1:0]    pc_plus1;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else            return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else            return c - 2'b01;
  endfunction

  // Combinational lookup of the fetch PC against current BTB contents
  always_comb begin
    lk_idx   = bus.pc_IF_w[BTB_IDX_BITS-1:0];
    lk_tag   = bus.pc_IF_w[WORD_SIZE-1:BTB_IDX_BITS];
    pc_plus1 = bus.pc_IF_w + PC_ONE;
    lk_hit   = valid[lk_idx] & (tag[lk_idx] == lk_tag) & ctr[lk_idx][1];
    bus.pred_taken_IF = lk_hit;
    if (lk_hit) bus.pred_next_pc = target[lk_idx];
    else        bus.pred_next_pc = pc_plus1;
  end

  // Misprediction detection; an older branch miss squashes the jump behind it
  always_comb begin
    bus.i_branch_miss = bus.b_valid_EX &
                        ((bus.b_pred_taken_EX != bus.b_taken_EX) |
                         (bus.b_taken_EX & (bus.b_pred_target_EX != bus.b_target_EX)));
    bus.jump_miss     = bus.j_valid_ID & ~bus.i_branch_miss &
                        (~bus.j_pred_taken_ID | (bus.j_pred_target_ID != bus.j_target_ID));
  end

  // Redirect PC: branch (older) has priority over jump
  always_comb begin
    if (bus.i_branch_miss) begin
      if (bus.b_taken_EX) bus.correct_pc = bus.b_target_EX;
      else                bus.correct_pc = bus.b_pc_EX + PC_ONE;
    end else if (bus.jump_miss) begin
      bus.correct_pc = bus.j_target_ID;
    end else begin
      bus.correct_pc = pc_plus1;
    end
  end

  // Update-side decode; a jump sharing the branch's index in the same cycle is dropped
  always_comb begin
    j_idx     = bus.j_pc_ID[BTB_IDX_BITS-1:0];
    j_tag     = bus.j_pc_ID[WORD_SIZE-1:BTB_IDX_BITS];
    b_idx     = bus.b_pc_EX[BTB_IDX_BITS-1:0];
    b_tag     = bus.b_pc_EX[WORD_SIZE-1:BTB_IDX_BITS];
    b_tag_hit = valid[b_idx] & (tag[b_idx] == b_tag);
    jump_we   = bus.j_valid_ID & ~bus.i_branch_miss &
                ~(bus.b_valid_EX & (b_idx == j_idx));
  end

  // BTB state update; reset clears every entry and discards pending updates
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= 2'b01;
      end
    end else begin
      if (jump_we) begin
        valid[j_idx]  <= 1'b1;
        tag[j_idx]    <= j_tag;
        target[j_idx] <= bus.j_target_ID;
        ctr[j_idx]    <= 2'b11;
      end
      if (bus.b_valid_EX) begin
        if (b_tag_hit) begin
          if (bus.b_taken_EX) begin
            ctr[b_idx]    <= ctr_inc(ctr[b_idx]);
            target[b_idx] <= bus.b_target_EX;
          end else begin
            ctr[b_idx]    <= ctr_dec(ctr[b_idx]);
          end
        end else if (bus.b_taken_EX) begin
          valid[b_idx]  <= 1'b1;
          tag[b_idx]    <= b_tag;
          target[b_idx] <= bus.b_target_EX;
          ctr[b_idx]    <= 2'b10;
        end
      end
    end
  end

`ifdef BP_STATS_EN
  logic [16:0] res_sum, miss_sum;

  // Next values of the statistics counters before saturation
  always_comb begin
    res_sum  = {1'b0, stat_resolved} + {16'h0000, bus.b_valid_EX}
             + {16'h0000, bus.j_valid_ID & ~bus.i_branch_miss};
    miss_sum = {1'b0, stat_miss} + {16'h0000, bus.i_branch_miss}
             + {16'h0000, bus.jump_miss};
  end

  // Saturating resolve/miss counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved <= 16'h0000;
      stat_miss     <= 16'h0000;
    end else begin
      stat_resolved <= res_sum[16]  ? 16'hFFFF : res_sum[15:0];
      stat_miss     <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected responses
// computed by a behavioural BTB model; a negedge monitor pops and compares.
module tb_branch_predictor;
  localparam int W  = 16;
  localparam int IB = 8;
  localparam int N  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.WORD_SIZE(W)) bus ();
`ifdef BP_STATS_EN
  logic [15:0] stat_resolved, stat_miss;
`endif

  branch_predictor #(.WORD_SIZE(W), .BTB_IDX_BITS(IB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BP_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_miss     (stat_miss)
`endif
  );

  typedef struct {
    int          step;
    logic        pt;
    logic [15:0] npc;
    logic        bm;
    logic        jm;
    logic [15:0] cpc;
    logic [15:0] sr;
    logic [15:0] sm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step     = 0;
  logic mon_vld  = 1'b0;

  // Behavioural BTB: plain per-index records
  bit m_valid [N];
  int m_tag   [N];
  int m_tgt   [N];
  int m_ctr   [N];
  int s_res   = 0;
  int s_miss  = 0;

  task automatic check(input string name, input int stp, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, stp, act, exp);
  endtask

  function automatic bit m_hit(input int pc);
    int i = pc % N;
    return m_valid[i] && (m_tag[i] == pc / N) && (m_ctr[i] >= 2);
  endfunction

  function automatic int m_pred(input int pc);
    if (m_hit(pc)) return m_tgt[pc % N];
    else return (pc + 1) % 65536;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    s_res  = 0;
    s_miss = 0;
  endtask

  // One cycle of stimulus with its expected response
  task automatic cyc(input bit rst, input int pc,
                     input bit jv, input int jpc, input bit jpt, input int jptg, input int jtg,
                     input bit bv, input int bpc, input bit bpt, input int bptg,
                     input bit btk, input int btg);
    exp_t e;
    bit   bm, jm;
    int   bi, ji;
    @(posedge clk);
    #1;
    reset                = rst;
    bus.pc_IF_w          = 16'(pc);
    bus.j_valid_ID       = jv;
    bus.j_pc_ID          = 16'(jpc);
    bus.j_pred_taken_ID  = jpt;
    bus.j_pred_target_ID = 16'(jptg);
    bus.j_target_ID      = 16'(jtg);
    bus.b_valid_EX       = bv;
    bus.b_pc_EX          = 16'(bpc);
    bus.b_pred_taken_EX  = bpt;
    bus.b_pred_target_EX = 16'(bptg);
    bus.b_taken_EX       = btk;
    bus.b_target_EX      = 16'(btg);
    step++;

    bm = bv && ((bpt != btk) || (btk && (bptg != btg)));
    jm = jv && !bm && (!jpt || (jptg != jtg));
    e.step = step;
    e.pt   = m_hit(pc);
    e.npc  = 16'(m_pred(pc));
    e.bm   = bm;
    e.jm   = jm;
    if (bm)      e.cpc = btk ? 16'(btg) : 16'((bpc + 1) % 65536);
    else if (jm) e.cpc = 16'(jtg);
    else         e.cpc = 16'((pc + 1) % 65536);
    e.sr = 16'(s_res);
    e.sm = 16'(s_miss);
    q.push_back(e);
    mon_vld = 1'b1;

    if (rst) begin
      m_reset();
    end else begin
      bi = bpc % N;
      ji = jpc % N;
      s_res  = s_res + int'(bv) + int'(jv && !bm);
      if (s_res > 65535) s_res = 65535;
      s_miss = s_miss + int'(bm) + int'(jm);
      if (s_miss > 65535) s_miss = 65535;
      if (jv && !bm && !(bv && bi == ji)) begin
        m_valid[ji] = 1'b1;
        m_tag[ji]   = jpc / N;
        m_tgt[ji]   = jtg;
        m_ctr[ji]   = 3;
      end
      if (bv) begin
        if (m_valid[bi] && m_tag[bi] == bpc / N) begin
          if (btk) begin
            m_ctr[bi] = (m_ctr[bi] == 3) ? 3 : m_ctr[bi] + 1;
            m_tgt[bi] = btg;
          end else begin
            m_ctr[bi] = (m_ctr[bi] == 0) ? 0 : m_ctr[bi] - 1;
          end
        end else if (btk) begin
          m_valid[bi] = 1'b1;
          m_tag[bi]   = bpc / N;
          m_tgt[bi]   = btg;
          m_ctr[bi]   = 2;
        end
      end
    end
  endtask

  task automatic lk(input int pc);
    cyc(1'b0, pc, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic br(input int bpc, input bit bpt, input int bptg, input bit btk, input int btg);
    cyc(1'b0, 16'h0000, 1'b0, 0, 1'b0, 0, 0, 1'b1, bpc, bpt, bptg, btk, btg);
  endtask

  task automatic jp(input int jpc, input bit jpt, input int jptg, input int jtg);
    cyc(1'b0, 16'h0000, 1'b1, jpc, jpt, jptg, jtg, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_vld) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        e = q.pop_front();
        check("pred_taken_IF", e.step, {15'h0000, bus.pred_taken_IF}, {15'h0000, e.pt});
        check("pred_next_pc",  e.step, bus.pred_next_pc, e.npc);
        check("i_branch_miss", e.step, {15'h0000, bus.i_branch_miss}, {15'h0000, e.bm});
        check("jump_miss",     e.step, {15'h0000, bus.jump_miss}, {15'h0000, e.jm});
        check("correct_pc",    e.step, bus.correct_pc, e.cpc);
`ifdef BP_STATS_EN
        check("stat_resolved", e.step, stat_resolved, e.sr);
        check("stat_miss",     e.step, stat_miss, e.sm);
`endif
      end
    end
  end

  initial begin
    int pc, bpc, jpc, tg, pool_idx;
    bit bv, jv, bpt, btk, jpt, rst;
    int bptg, jptg;
    int pool [4];
    pool[0] = 5; pool[1] = 6; pool[2] = 64; pool[3] = 65;

    bus.pc_IF_w = 16'h0000;
    bus.j_valid_ID = 1'b0; bus.j_pc_ID = 16'h0000; bus.j_pred_taken_ID = 1'b0;
    bus.j_pred_target_ID = 16'h0000; bus.j_target_ID = 16'h0000;
    bus.b_valid_EX = 1'b0; bus.b_pc_EX = 16'h0000; bus.b_pred_taken_EX = 1'b0;
    bus.b_pred_target_EX = 16'h0000; bus.b_taken_EX = 1'b0; bus.b_target_EX = 16'h0000;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset state at several indices
    lk(16'h0040); lk(16'h0000); lk(16'h00FF); lk(16'h1234);
    // Taken branch mispredict allocates, then counter walks down
    br(16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0010);
    lk(16'h0040);
    br(16'h0040, 1'b1, 16'h0010, 1'b0, 16'h0010);
    br(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0010);
    lk(16'h0040);
    br(16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0010);
    lk(16'h0040);
    // Unconditional jump miss and learned target
    jp(16'h0100, 1'b0, 16'h0000, 16'h0200);
    lk(16'h0100);
    jp(16'h0100, 1'b1, 16'h0200, 16'h0200);
    // Branch miss suppresses younger jump
    cyc(1'b0, 16'h0052, 1'b1, 16'h0051, 1'b0, 16'h0000, 16'h0300,
        1'b1, 16'h0050, 1'b1, 16'h0060, 1'b0, 16'h0060);
    lk(16'h0051);
    // Same-index collision: branch wins
    cyc(1'b0, 16'h0005, 1'b1, 16'h0105, 1'b0, 16'h0000, 16'h0700,
        1'b1, 16'h0005, 1'b1, 16'h0900, 1'b1, 16'h0900);
    lk(16'h0105); lk(16'h0005);
    jp(16'h0105, 1'b0, 16'h0000, 16'h0700);
    lk(16'h0105); lk(16'h0005);
    // PC increment and wrap
    lk(16'h0FFF); lk(16'hFFFF);
    // Reset during an update discards it
    cyc(1'b1, 16'h0077, 1'b1, 16'h0077, 1'b0, 16'h0000, 16'h0500,
        1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 16'h0600);
    lk(16'h0077); lk(16'h0100);

    // Randomized traffic on a small PC pool to force hits and aliasing
    for (int k = 0; k < 500; k++) begin
      pool_idx = int'($urandom_range(0, 3));
      pc   = ($urandom_range(0, 2) * N) + pool[pool_idx];
      bpc  = ($urandom_range(0, 2) * N) + pool[$urandom_range(0, 3)];
      jpc  = ($urandom_range(0, 2) * N) + pool[$urandom_range(0, 3)];
      bv   = ($urandom_range(0, 2) != 0);
      jv   = ($urandom_range(0, 2) == 0);
      btk  = $urandom_range(0, 1) == 1;
      tg   = 16'h0800 + 16 * $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        bpt  = m_hit(bpc);
        bptg = m_pred(bpc);
      end else begin
        bpt  = $urandom_range(0, 1) == 1;
        bptg = tg;
      end
      jpt  = $urandom_range(0, 1) == 1;
      jptg = 16'h0C00 + 16 * $urandom_range(0, 1);
      rst  = ($urandom_range(0, 63) == 0);
      cyc(rst, pc, jv, jpc, jpt, jptg, 16'h0C00, bv, bpc, bpt, bptg, btk, tg);
    end

    @(posedge clk);
    #1;
    mon_vld = 1'b0;
    bus.j_valid_ID = 1'b0;
    bus.b_valid_EX = 1'b0;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
